mem_ctrl: RTL and testbench
===========================

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter MEM_WIDTH, default 16: data word width.
REQ-002 SHALL have parameter MEM_DEPTH, default 256: RAM words; ADDR_WIDTH = clog2(MEM_DEPTH) is local, not overridable.
REQ-003 SHALL have port clk  input  1: single clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1: reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  input  1: host request present.
REQ-006 SHALL have port req_ready  output  1: controller accepts request this cycle.
REQ-007 SHALL have port req_we  input  1: 1 = write, 0 = read.
REQ-008 SHALL have port req_addr  input  ADDR_WIDTH: start address.
REQ-009 SHALL have port req_len  input  2: read burst length minus one (1..4 words); ignored for writes.
REQ-010 SHALL have port req_wdata  input  MEM_WIDTH: write data.
REQ-011 SHALL have port resp_valid  output  1: read word available.
REQ-012 SHALL have port resp_ready  input  1: host consumes read word.
REQ-013 SHALL have port resp_data  output  MEM_WIDTH: read word (MDR contents).
REQ-014 SHALL have port resp_last  output  1: final word of burst.
REQ-015 SHALL have ports ram_addr (output, ADDR_WIDTH), ram_r_en (output, 1), ram_w_en (output, 1), ram_wdata (output, MEM_WIDTH), and ram_rdata (input, MEM_WIDTH): RAM side; RAM reads combinationally while r_en is high and writes on the clock edge while w_en is high.

Function
REQ-016 SHALL implement FSM states IDLE, RD, RESP, WR; req_ready is high only in IDLE.
REQ-017 SHALL accept a request on the edge where req_valid and req_ready are both high, loading MAR = req_addr, MDR = req_wdata, and remaining = req_len (0 for writes).
REQ-018 SHALL transition IDLE->WR on an accepted write; WR drives ram_w_en=1, ram_addr=MAR, and ram_wdata=MDR for exactly one cycle, then returns to IDLE (write latency: 1 cycle after accept; no response).
REQ-019 SHALL transition IDLE->RD on an accepted read; RD drives ram_r_en=1 and ram_addr=MAR for one cycle and captures ram_rdata into MDR at the closing edge, then enters RESP.
REQ-020 SHALL hold resp_valid=1 with stable resp_data and resp_last in RESP until resp_ready; resp_last = (remaining == 0).
REQ-021 SHALL, on the RESP handshake edge, go to IDLE when remaining == 0; otherwise it decrements remaining, increments MAR, and goes to RD.
REQ-022 SHALL wrap MAR modulo MEM_DEPTH (MEM_DEPTH-1 + 1 -> 0).
REQ-023 SHALL never assert ram_r_en and ram_w_en in the same cycle; both are 0 outside RD and WR respectively.
REQ-024 SHALL hold ram_addr at MAR in all states and ram_wdata at MDR.
REQ-025 SHALL give first-word read latency = 2 cycles after accept (resp_valid visible in 2nd cycle), and back-to-back burst words every 2 cycles with resp_ready held high.
REQ-026 SHALL ignore req_valid outside IDLE; the host holds the request until accepted.

Reset
REQ-027 SHALL, while rst_n=0 (asynchronous assert, any state, including mid-burst), force state IDLE, MAR=0, MDR=0, remaining=0, resp_valid=0, resp_last=0, ram_r_en=0, and ram_w_en=0; pending burst discarded.
REQ-028 SHALL have req_ready=1 in the first cycle after rst_n deasserts; deassertion is synchronized to clk by the integrator.

Structure
REQ-029 SHALL place the FSM state enumeration and MAX_BURST=4 constant in shared package mem_ctrl_pkg.
REQ-030 SHALL be a single module; no sub-module required.

Verification
REQ-031 SHALL verify single write: write addr 0x10, data 0xBEEF -> ram_w_en high exactly one cycle with ram_addr=0x10, ram_wdata=0xBEEF; req_ready high next cycle.
REQ-032 SHALL verify single read: RAM model holds 0xBEEF at 0x10, read len=0 -> resp_valid in 2nd cycle, resp_data=0xBEEF, resp_last=1.
REQ-033 SHALL verify burst with wrap: read addr 0xFE, len=3 -> ram_addr sequence 0xFE, 0xFF, 0x00, 0x01; resp_last only on 4th word.
REQ-034 SHALL verify backpressure: resp_ready low 5 cycles during burst -> resp_data stable, no ram_r_en pulses, no word lost.
REQ-035 SHALL verify reset mid-burst: rst_n low during 2nd RD of len=3 -> all outputs 0 immediately, req_ready=1 after release, no further responses.
REQ-036 SHALL verify exclusivity: random request stream of 1000 requests -> ram_r_en and ram_w_en never high together; every read data matches the model.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared FSM states and burst constants for the memory controller
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    RESP = 2'd2,
    WR   = 2'd3
  } state_t;

  localparam int MAX_BURST = 4;
  localparam int LEN_WIDTH = $clog2(MAX_BURST);

endpackage

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - single-port RAM controller: one-word writes, 1..4 word read bursts
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int MEM_WIDTH = 16,
  parameter int MEM_DEPTH = 256,
  localparam int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LEN_WIDTH-1:0]  req_len,
  input  logic [MEM_WIDTH-1:0]  req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [MEM_WIDTH-1:0]  resp_data,
  output logic                  resp_last,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_r_en,
  output logic                  ram_w_en,
  output logic [MEM_WIDTH-1:0]  ram_wdata,
  input  logic [MEM_WIDTH-1:0]  ram_rdata
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] mar, mar_n;
  logic [MEM_WIDTH-1:0]  mdr, mdr_n;
  logic [LEN_WIDTH-1:0]  remaining, remaining_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mar       <= '0;
      mdr       <= '0;
      remaining <= '0;
    end else begin
      state     <= state_n;
      mar       <= mar_n;
      mdr       <= mdr_n;
      remaining <= remaining_n;
    end
  end

  always_comb begin
    state_n     = state;
    mar_n       = mar;
    mdr_n       = mdr;
    remaining_n = remaining;
    case (state)
      IDLE: begin
        if (req_valid) begin
          mar_n       = req_addr;
          mdr_n       = req_wdata;
          remaining_n = req_we ? '0 : req_len;
          state_n     = req_we ? WR : RD;
        end
      end
      RD: begin
        mdr_n   = ram_rdata;
        state_n = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          if (remaining == '0) begin
            state_n = IDLE;
          end else begin
            // Explicit wrap keeps non-power-of-two depths inside the array.
            remaining_n = remaining - 1'b1;
            mar_n       = (mar == LAST_ADDR) ? '0 : mar + 1'b1;
            state_n     = RD;
          end
        end
      end
      WR:      state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_last  = (state == RESP) && (remaining == '0);
  assign resp_data  = mdr;
  assign ram_addr   = mar;
  assign ram_wdata  = mdr;
  assign ram_r_en   = (state == RD);
  assign ram_w_en   = (state == WR);

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - directed and randomized self-checking bench for mem_ctrl
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [7:0]  req_addr;
  logic [1:0]  req_len;
  logic [15:0] req_wdata;
  logic        resp_valid, resp_ready, resp_last;
  logic [15:0] resp_data;
  logic [7:0]  ram_addr;
  logic        ram_r_en, ram_w_en;
  logic [15:0] ram_wdata, ram_rdata;

  logic [15:0] ram [256];
  logic [15:0] ref_mem [256];

  int checks = 0;
  int fails  = 0;

  mem_ctrl #(.MEM_WIDTH(16), .MEM_DEPTH(256)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_last(resp_last),
    .ram_addr(ram_addr), .ram_r_en(ram_r_en), .ram_w_en(ram_w_en),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_w_en) ram[ram_addr] <= ram_wdata;
  assign ram_rdata = ram_r_en ? ram[ram_addr] : 16'h0000;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check("excl", {31'd0, ram_r_en & ram_w_en}, 32'd0);
  endtask

  task automatic drive_junk(input bit junk);
    req_valid = junk ? 1'($urandom) : 1'b0;
    req_we    = 1'($urandom);
    req_addr  = 8'($urandom);
    req_len   = 2'($urandom);
    req_wdata = 16'($urandom);
  endtask

  task automatic write_word(input logic [7:0] addr, input logic [15:0] data, input bit junk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = addr; req_wdata = data; req_len = 2'($urandom);
    check("wr_ready", req_ready, 1);
    tick();
    drive_junk(junk);
    check("wr_wen", ram_w_en, 1);
    check("wr_addr", ram_addr, addr);
    check("wr_data", ram_wdata, data);
    check("wr_busy", req_ready, 0);
    check("wr_noresp", resp_valid, 0);
    tick();
    req_valid = 1'b0;
    check("wr_wen_off", ram_w_en, 0);
    check("wr_ready_after", req_ready, 1);
    ref_mem[addr] = data;
  endtask

  task automatic read_burst(input logic [7:0] addr, input logic [1:0] len,
                            input int stall_word, input int stall_n, input bit junk);
    logic [7:0] a;
    req_valid = 1'b1; req_we = 1'b0; req_addr = addr; req_len = len;
    req_wdata = 16'($urandom);
    resp_ready = 1'b1;
    check("rd_ready", req_ready, 1);
    for (int i = 0; i <= int'(len); i++) begin
      a = addr + 8'(i);
      tick();
      drive_junk(junk);
      check("rd_ren", ram_r_en, 1);
      check("rd_addr", ram_addr, a);
      check("rd_novalid", resp_valid, 0);
      if (i == stall_word) begin
        resp_ready = 1'b0;
        for (int k = 0; k < stall_n; k++) begin
          tick();
          check("bp_valid", resp_valid, 1);
          check("bp_data", resp_data, ref_mem[a]);
          check("bp_last", resp_last, (i == int'(len)) ? 1 : 0);
          check("bp_noren", ram_r_en, 0);
        end
        resp_ready = 1'b1;
      end else begin
        tick();
        check("rs_valid", resp_valid, 1);
        check("rs_data", resp_data, ref_mem[a]);
        check("rs_last", resp_last, (i == int'(len)) ? 1 : 0);
      end
    end
    tick();
    req_valid = 1'b0;
    check("rd_done_valid", resp_valid, 0);
    check("rd_done_ready", req_ready, 1);
  endtask

  initial begin
    logic [15:0] v;
    for (int i = 0; i < 256; i++) begin
      v = 16'($urandom);
      ram[i] = v;
      ref_mem[i] = v;
    end
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_len = '0;
    req_wdata = '0; resp_ready = 1'b0;

    // reset state
    tick(); tick();
    check("rst_valid", resp_valid, 0);
    check("rst_last", resp_last, 0);
    check("rst_ren", ram_r_en, 0);
    check("rst_wen", ram_w_en, 0);
    check("rst_addr", ram_addr, 0);
    check("rst_data", resp_data, 0);
    rst_n = 1'b1;
    tick();
    check("rst_ready", req_ready, 1);

    // single write then single read
    write_word(8'h10, 16'hBEEF, 1'b0);
    check("ram_written", ram[8'h10], 16'hBEEF);
    read_burst(8'h10, 2'd0, -1, 0, 1'b0);

    // burst with address wrap
    read_burst(8'hFE, 2'd3, -1, 0, 1'b0);

    // backpressure on the second word
    read_burst(8'h20, 2'd3, 1, 5, 1'b0);

    // reset asserted during the second RD of a burst
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h40; req_len = 2'd3; resp_ready = 1'b1;
    tick(); req_valid = 1'b0;
    tick();
    check("mid_first", resp_data, ref_mem[8'h40]);
    tick();
    check("mid_rd2_ren", ram_r_en, 1);
    check("mid_rd2_addr", ram_addr, 8'h41);
    #2 rst_n = 1'b0;
    #1;
    check("mid_ren", ram_r_en, 0);
    check("mid_wen", ram_w_en, 0);
    check("mid_valid", resp_valid, 0);
    check("mid_last", resp_last, 0);
    check("mid_addr", ram_addr, 0);
    check("mid_data", resp_data, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("mid_ready", req_ready, 1);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("mid_noresp", resp_valid, 0);
      check("mid_noren", ram_r_en, 0);
    end

    // random request stream
    for (int n = 0; n < 1000; n++) begin
      int gap;
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        tick();
        check("gap_ready", req_ready, 1);
      end
      if ($urandom_range(0, 1) == 1) begin
        write_word(8'($urandom), 16'($urandom), 1'($urandom));
      end else begin
        logic [1:0] l;
        l = 2'($urandom);
        read_burst(8'($urandom), l,
                   ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, int'(l))) : -1,
                   int'($urandom_range(1, 3)), 1'($urandom));
      end
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
